// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_pkg
// Purpose  : Shared definitions for the instruction-memory program loader.
//            This package holds the loader FSM state encoding, the frame
//            layout constants and the instruction-memory geometry defaults.
//            The instruction memory uses the same geometry defaults.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Instruction memory geometry defaults.
    localparam int c_depth_default  = 1024;
    localparam int c_addr_w_default = 10;

    // Frame layout: a 2-byte little-endian word count, then 4 bytes per word.
    localparam int c_hdr_bytes      = 2;
    localparam int c_bytes_per_word = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    // States in which a frame is in progress and stream bytes are accepted.
    function automatic logic st_in_frame(input state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_DATA)   || (s == ST_CHECK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_word_packer
// Purpose  : Assembles little-endian 32-bit words from a byte stream and
//            keeps a running XOR of every byte it is given.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_clear         - synchronous clear of index, shift reg, checksum
//            i_byte_valid    - accept i_byte this cycle
//            i_byte          - payload byte
//            o_word_valid    - i_byte completes a word this cycle
//            o_word          - assembled word (valid with o_word_valid)
//            o_checksum      - XOR of all bytes accepted since the last clear
// Revision : 1.0 - initial release
// ============================================================================
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word,
    output logic [7:0]  o_checksum
);

    localparam logic [1:0] c_last_idx = 2'(c_bytes_per_word - 1);

    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic [7:0]  r_xor;

    // The word is completed combinationally from the fourth byte. The loader
    // can then register the write on the same edge as the handshake.
    assign o_word_valid = i_byte_valid && (r_idx == c_last_idx);
    assign o_word       = {i_byte, r_shift};
    assign o_checksum   = r_xor;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_idx   <= 2'd0;
            r_shift <= 24'd0;
            r_xor   <= 8'd0;
        end else if (i_byte_valid) begin
            r_xor   <= r_xor ^ i_byte;
            // Shift right so the first byte of a word lands in bits 7:0.
            r_shift <= {i_byte, r_shift[23:8]};
            // The index wraps from 3 to 0 on its own at the end of each word.
            r_idx   <= r_idx + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Purpose  : Fills the instruction memory from a framed host byte stream
//            (LEN_LO, LEN_HI, 4*N little-endian payload bytes, XOR checksum).
//            It holds the CPU in reset until a load completes successfully.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            io_start        - arms a load (honoured in IDLE/DONE/ERR)
//            io_in_*         - byte stream, valid/ready handshake
//            io_wr_*         - instruction-memory write port, one strobe/word
//            io_busy         - frame in progress
//            io_done/io_err  - outcome of the last load
//            io_cpu_reset    - high unless the last load succeeded
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = c_depth_default,
    parameter int ADDR_W = c_addr_w_default
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_in_valid,
    input  logic [7:0]        io_in_bits,
    output logic              io_in_ready,
    output logic              io_wr_en,
    output logic [ADDR_W-1:0] io_wr_addr,
    output logic [31:0]       io_wr_data,
    output logic              io_busy,
    output logic              io_done,
    output logic              io_err,
    output logic              io_cpu_reset
);

    localparam logic [16:0] c_depth = 17'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_len_lo;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_word_cnt;

    logic        w_hs;
    logic        w_start;
    logic [15:0] w_len;
    logic        w_last_word;
    logic        w_word_valid;
    logic [31:0] w_word;
    logic [7:0]  w_checksum;

    assign w_hs    = io_in_valid && io_in_ready;
    assign w_start = io_start && !st_in_frame(r_state);
    assign w_len   = {io_in_bits, r_len_lo};
    // The word now completing is the last one when its index is N-1.
    assign w_last_word = ((16'(r_word_cnt) + 16'd1) == r_len);

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (reset),
        .i_clear      (w_start),
        .i_byte_valid (w_hs && (r_state == ST_DATA)),
        .i_byte       (io_in_bits),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_checksum   (w_checksum)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (io_start) w_state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (w_hs) w_state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (w_hs) begin
                    if ({1'b0, w_len} > c_depth) w_state_nxt = ST_ERR;
                    else if (w_len == 16'd0)     w_state_nxt = ST_CHECK;
                    else                         w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_valid && w_last_word) w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_hs) w_state_nxt = (io_in_bits == w_checksum) ? ST_DONE : ST_ERR;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state, so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_word_cnt   <= '0;
            io_in_ready  <= 1'b0;
            io_wr_en     <= 1'b0;
            io_wr_addr   <= '0;
            io_wr_data   <= 32'd0;
            io_busy      <= 1'b0;
            io_done      <= 1'b0;
            io_err       <= 1'b0;
            io_cpu_reset <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            io_in_ready  <= st_in_frame(w_state_nxt);
            io_busy      <= st_in_frame(w_state_nxt);
            io_done      <= (w_state_nxt == ST_DONE);
            io_err       <= (w_state_nxt == ST_ERR);
            io_cpu_reset <= (w_state_nxt != ST_DONE);
            io_wr_en     <= w_word_valid;

            if (w_word_valid) begin
                io_wr_addr <= r_word_cnt;
                io_wr_data <= w_word;
                r_word_cnt <= r_word_cnt + ADDR_W'(1);
            end
            if (w_start) r_word_cnt <= '0;

            if ((r_state == ST_LEN_LO) && w_hs) r_len_lo <= io_in_bits;
            if ((r_state == ST_LEN_HI) && w_hs) r_len    <= w_len;
        end
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader that fills the core's instruction memory from a byte stream (host/UART side), i.e. the writer for the instruction fetch read port.
- Accepts a framed byte stream: length header, little-endian instruction words, XOR checksum.
- Issues one 32-bit write per assembled word and holds the CPU in reset until a load completes successfully.
- Sits between the host byte receiver and the write port of the instruction memory.

Parameters:
- DEPTH, 1024, number of 32-bit words in instruction memory.
- ADDR_W, 10, word-address width; log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_start  input  1  one-cycle pulse that arms a load; honoured in IDLE, DONE and ERR only.
- io_in_valid  input  1  byte-stream valid.
- io_in_bits  input  8  byte-stream data.
- io_in_ready  output  1  loader accepts a byte when io_in_valid && io_in_ready.
- io_wr_en  output  1  instruction-memory write strobe, one cycle per word.
- io_wr_addr  output  ADDR_W  word address of the write.
- io_wr_data  output  32  instruction word.
- io_busy  output  1  high while a frame is in progress.
- io_done  output  1  high in DONE (last load succeeded).
- io_err  output  1  high in ERR (last load failed).
- io_cpu_reset  output  1  high in every state except DONE.

Behaviour:
- Reset: state=IDLE; io_in_ready=0, io_wr_en=0, io_wr_addr=0, io_wr_data=0, io_busy=0, io_done=0, io_err=0, io_cpu_reset=1; internal counters, checksum and byte shift register cleared. Memory contents are untouched.
- Frame format: LEN_LO, LEN_HI (N, 16-bit little-endian word count), then 4*N payload bytes (each word little-endian: first byte -> bits 7:0), then 1 checksum byte equal to the XOR of all payload bytes (length bytes excluded).
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR. io_in_ready=1 exactly in LEN_LO, LEN_HI, DATA and CHECK.
- IDLE/DONE/ERR, io_start -> LEN_LO. This clears the word counter, byte index and checksum, and drops io_done/io_err the next cycle.
- LEN_LO, on handshake -> LEN_HI.
- LEN_HI, on handshake: if N > DEPTH -> ERR; if N == 0 -> CHECK; else -> DATA.
- DATA: each accepted byte is XORed into the checksum and shifted into the word at byte index 0..3.
  - On the 4th byte, the next cycle drives io_wr_en=1 for exactly one cycle, with io_wr_addr = word counter and io_wr_data = assembled word.
  - The word counter then increments. Write latency is 1 cycle after the last byte's handshake.
  - After the write of word N-1 -> CHECK. Back-to-back bytes at full rate are sustained.
- CHECK, on handshake: byte == checksum -> DONE; else -> ERR. With N == 0, the expected checksum is 0x00.
- Gaps in io_in_valid stall the FSM with no state change. io_in_bits is ignored when io_in_valid=0.
- io_start while busy (LEN_LO..CHECK) is ignored.
- Reset mid-load returns to IDLE. Words already written remain in memory; io_cpu_reset stays high.
- io_wr_addr wraps never: N <= DEPTH guarantees addresses 0..N-1 only.
- io_busy=1 in LEN_LO, LEN_HI, DATA, CHECK.

Decomposition:
- Shared package holds the FSM state encoding (7 states, 3 bits), the frame constants (header length 2, bytes per word 4), and DEPTH/ADDR_W defaults shared with the instruction memory.
- One natural sub-module, imem_word_packer: byte index counter, little-endian shift register, running XOR; emits word_valid/word.
- The FSM, address counter and write port stay in imem_loader.

Test Plan:
- Normal load: io_start; bytes 02 00 13 00 00 00 B3 00 A0 00, checksum 0x00 (13^B3^A0 = 0x00). Required: writes addr0=0x00000013 and addr1=0x00A000B3, each a single-cycle io_wr_en; then io_done=1, io_cpu_reset=0.
- Checksum error: same frame with checksum 0xFF -> both writes still occur; io_err=1, io_done=0, io_cpu_reset=1.
- Oversize/empty:
  - Length 01 04 (N=1025) -> ERR right after LEN_HI, no writes.
  - Length 00 00 then checksum 00 -> DONE, no writes.
- Backpressure/gaps: normal frame with io_in_valid toggled every other cycle and io_start pulsed mid-frame -> identical writes and outcome; start ignored.
- Reset mid-load: assert reset after 5 payload bytes -> IDLE, io_in_ready=0, one completed write only. A new io_start plus a full frame then loads correctly from addr 0.
- Reload after DONE: io_start in DONE -> io_done drops the next cycle, io_cpu_reset=1; a second frame overwrites addr0 with the new value.
